// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store
// traffic onto a single 8-bit RAM/IO port, with IO back-pressure on stores.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        clear
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_base;
  logic [KW-1:0] r_n;
  logic          r_owner_ls;
  logic [DW-1:0] r_wdata;
  logic [KW-1:0] r_k;
  logic [DW-1:0] r_buf;

  logic [KW-1:0] w_size_n;
  logic          w_accept;
  logic [AW-1:0] w_acc_addr;
  logic          w_acc_wr;
  logic          w_acc_stall;
  logic [AW-1:0] w_wr_addr;
  logic          w_wr_stall;
  logic [7:0]    w_wr_byte;
  logic [KW-1:0] w_rd_edge;
  logic          w_rd_last;
  logic [1:0]    w_cap_sel;
  logic [1:0]    w_last_sel;
  logic [DW-1:0] w_rd_word;

  // Byte count of a load/store; size 3 behaves as a word.
  always_comb begin
    w_size_n = 3'd4;
    case (ls_size)
      2'd0:    w_size_n = 3'd1;
      2'd1:    w_size_n = 3'd2;
      default: w_size_n = 3'd4;
    endcase
  end

  // Acceptance: load/store has priority over fetch.
  assign w_accept    = (r_state == ST_IDLE) && !clear && !if_done && !ls_done &&
                       (ls_req || if_req);
  assign w_acc_addr  = ls_req ? ls_addr : if_addr;
  assign w_acc_wr    = ls_req && ls_wr;
  assign w_acc_stall = io_buffer_full && (w_acc_addr[17:16] == 2'b11);

  // r_k counts bytes already issued in WRITE.
  assign w_wr_addr  = r_base + AW'(r_k);
  assign w_wr_stall = io_buffer_full && (w_wr_addr[17:16] == 2'b11);
  assign w_wr_byte  = 8'(r_wdata >> {r_k[1:0], 3'b000});

  // In READ, r_k counts edges since acceptance; w_rd_edge is the edge being taken.
  assign w_rd_edge  = r_k + 3'd1;
  assign w_rd_last  = (w_rd_edge == (r_n + 3'd1));
  assign w_cap_sel  = 2'(w_rd_edge - 3'd2);
  assign w_last_sel = 2'(r_n - 3'd1);

  // Completed word: buffered low bytes plus the final byte arriving now.
  always_comb begin
    w_rd_word = r_buf;
    w_rd_word[{w_last_sel, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_n        <= '0;
      r_owner_ls <= 1'b0;
      r_wdata    <= '0;
      r_k        <= '0;
      r_buf      <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      if_done    <= 1'b0;
      if_data    <= '0;
      ls_done    <= 1'b0;
      ls_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          mem_wr <= 1'b0;
          if (w_accept) begin
            r_base     <= w_acc_addr;
            r_n        <= ls_req ? w_size_n : 3'd4;
            r_owner_ls <= ls_req;
            r_wdata    <= ls_wdata;
            r_buf      <= '0;
            mem_a      <= w_acc_addr;
            if (w_acc_wr) begin
              r_state <= ST_WRITE;
              if (w_acc_stall) begin
                r_k <= 3'd0;
              end else begin
                mem_wr   <= 1'b1;
                mem_dout <= ls_wdata[7:0];
                r_k      <= 3'd1;
              end
            end else begin
              r_state <= ST_READ;
              r_k     <= 3'd0;
            end
          end
        end

        ST_READ: begin
          mem_wr <= 1'b0;
          if (clear) begin
            r_state <= ST_IDLE;
            r_k     <= 3'd0;
          end else if (w_rd_last) begin
            r_state <= ST_IDLE;
            r_k     <= 3'd0;
            if (r_owner_ls) begin
              ls_done  <= 1'b1;
              ls_rdata <= w_rd_word;
            end else begin
              if_done <= 1'b1;
              if_data <= w_rd_word;
            end
          end else begin
            r_k <= w_rd_edge;
            if (w_rd_edge < r_n) begin
              mem_a <= r_base + AW'(w_rd_edge);
            end
            if (w_rd_edge >= 3'd2) begin
              r_buf[{w_cap_sel, 3'b000} +: 8] <= mem_din;
            end
          end
        end

        ST_WRITE: begin
          if (r_k == r_n) begin
            mem_wr  <= 1'b0;
            ls_done <= 1'b1;
            r_state <= ST_IDLE;
            r_k     <= 3'd0;
          end else if (w_wr_stall) begin
            mem_wr <= 1'b0;
          end else begin
            mem_wr   <= 1'b1;
            mem_a    <= w_wr_addr;
            mem_dout <= w_wr_byte;
            r_k      <= r_k + 3'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          mem_wr  <= 1'b0;
          r_k     <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: behavioural RAM with a write log, one
// linear sequence of steps with hand-computed expectations.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        clear;

  int nvec  = 0;
  int nfail = 0;

  logic [7:0]  ram [0:131071];
  logic [31:0] wa_q [$];
  logic [7:0]  wd_q [$];

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata), .clear(clear)
  );

  always #5 clk_in = ~clk_in;

  // RAM: data for an address sampled at an edge appears after that edge.
  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[16:0]];
    if (mem_wr === 1'b1) begin
      wa_q.push_back(mem_a);
      wd_q.push_back(mem_dout);
      if (mem_a[17:16] != 2'b11) ram[mem_a[16:0]] <= mem_dout;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
    ram[17'h01000] = 8'h13;
    ram[17'h01001] = 8'h05;
    ram[17'h00010] = 8'h80;
    mem_din = 8'h00;
    rst_in = 1'b1; io_buffer_full = 1'b0; clear = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = '0; ls_wdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_ls_done", 32'(ls_done), 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    rst_in = 1'b0;
    tick();

    // Fetch 0x1000 -> 0x00000513, done after edge 5
    if_req = 1'b1; if_addr = 32'h1000;
    tick();
    chk("f0_mem_a_e0", mem_a, 32'h1000);
    chk("f0_mem_wr_e0", 32'(mem_wr), 32'd0);
    tick(); tick(); tick(); tick();
    chk("f0_if_done_e4", 32'(if_done), 32'd0);
    tick();
    chk("f0_if_done_e5", 32'(if_done), 32'd1);
    chk("f0_if_data", if_data, 32'h0000_0513);
    if_req = 1'b0;
    tick();
    chk("f0_if_done_e6", 32'(if_done), 32'd0);
    chk("f0_if_data_hold", if_data, 32'h0000_0513);

    // Half store 0xBEEF at 0x2001
    clr_log();
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h2001; ls_wdata = 32'h0000_BEEF;
    tick();
    chk("s1_wr_e0", 32'(mem_wr), 32'd1);
    chk("s1_a_e0", mem_a, 32'h2001);
    chk("s1_dout_e0", 32'(mem_dout), 32'hEF);
    tick();
    chk("s1_wr_e1", 32'(mem_wr), 32'd1);
    chk("s1_a_e1", mem_a, 32'h2002);
    chk("s1_dout_e1", 32'(mem_dout), 32'hBE);
    chk("s1_done_e1", 32'(ls_done), 32'd0);
    tick();
    chk("s1_done_e2", 32'(ls_done), 32'd1);
    chk("s1_wr_e2", 32'(mem_wr), 32'd0);
    ls_req = 1'b0; ls_wr = 1'b0;
    tick();
    chk("s1_done_e3", 32'(ls_done), 32'd0);
    chk("s1_nwrites", 32'(wa_q.size()), 32'd2);
    chk("s1_ram2000", 32'(ram[17'h02000]), 32'h00);
    chk("s1_ram2001", 32'(ram[17'h02001]), 32'hEF);
    chk("s1_ram2002", 32'(ram[17'h02002]), 32'hBE);
    chk("s1_ram2003", 32'(ram[17'h02003]), 32'h00);

    // Simultaneous fetch 0x2000 and load byte 0x10: load first
    if_req = 1'b1; if_addr = 32'h2000;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h10;
    tick();
    chk("arb_a_e0", mem_a, 32'h10);
    tick(); tick();
    chk("arb_ls_done", 32'(ls_done), 32'd1);
    chk("arb_ls_rdata", ls_rdata, 32'h0000_0080);
    chk("arb_if_done_e2", 32'(if_done), 32'd0);
    ls_req = 1'b0;
    tick();
    chk("arb_ls_done_e3", 32'(ls_done), 32'd0);
    chk("arb_no_acc_e3", mem_a, 32'h10);
    tick();
    chk("arb_fetch_acc_e4", mem_a, 32'h2000);
    tick(); tick(); tick(); tick();
    chk("arb_if_done_e8", 32'(if_done), 32'd0);
    tick();
    chk("arb_if_done_e9", 32'(if_done), 32'd1);
    chk("arb_if_data", if_data, 32'h00BE_EF00);
    chk("arb_ls_rdata_hold", ls_rdata, 32'h0000_0080);
    if_req = 1'b0;
    tick();

    // IO store stalled 3 cycles
    clr_log();
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_0041;
    tick();
    chk("io_wr_e0", 32'(mem_wr), 32'd0);
    tick();
    chk("io_wr_e1", 32'(mem_wr), 32'd0);
    tick();
    chk("io_wr_e2", 32'(mem_wr), 32'd0);
    chk("io_done_e2", 32'(ls_done), 32'd0);
    io_buffer_full = 1'b0;
    tick();
    chk("io_wr_e3", 32'(mem_wr), 32'd1);
    chk("io_a_e3", mem_a, 32'h0003_0000);
    chk("io_dout_e3", 32'(mem_dout), 32'h41);
    chk("io_done_e3", 32'(ls_done), 32'd0);
    tick();
    chk("io_done_e4", 32'(ls_done), 32'd1);
    chk("io_wr_e4", 32'(mem_wr), 32'd0);
    ls_req = 1'b0; ls_wr = 1'b0;
    tick();
    chk("io_nwrites", 32'(wa_q.size()), 32'd1);

    // Clear at edge 2 of fetch aborts; new fetch accepted at edge 3
    if_req = 1'b1; if_addr = 32'h2000;
    tick(); tick();
    clear = 1'b1; if_req = 1'b0;
    tick();
    clear = 1'b0; if_req = 1'b1; if_addr = 32'h1000;
    tick();
    chk("clr_acc_e3", mem_a, 32'h1000);
    chk("clr_if_done_e3", 32'(if_done), 32'd0);
    tick(); tick();
    chk("clr_if_done_e5", 32'(if_done), 32'd0);
    chk("clr_if_data_hold", if_data, 32'h00BE_EF00);
    tick(); tick(); tick();
    chk("clr_new_done", 32'(if_done), 32'd1);
    chk("clr_new_data", if_data, 32'h0000_0513);
    if_req = 1'b0;
    tick();

    // Clear at edge 1 of word store is ignored
    clr_log();
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h3000; ls_wdata = 32'hDDCC_BBAA;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick();
    chk("wclr_done_e3", 32'(ls_done), 32'd0);
    tick();
    chk("wclr_done_e4", 32'(ls_done), 32'd1);
    ls_req = 1'b0; ls_wr = 1'b0;
    tick();
    chk("wclr_nwrites", 32'(wa_q.size()), 32'd4);
    chk("wclr_ram3000", 32'(ram[17'h03000]), 32'hAA);
    chk("wclr_ram3003", 32'(ram[17'h03003]), 32'hDD);

    // Reset at edge 2 of word store
    clr_log();
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd3; ls_addr = 32'h4000; ls_wdata = 32'h4433_2211;
    tick(); tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
    chk("rw_mem_wr", 32'(mem_wr), 32'd0);
    chk("rw_mem_a", mem_a, 32'd0);
    chk("rw_mem_dout", 32'(mem_dout), 32'd0);
    chk("rw_ls_done", 32'(ls_done), 32'd0);
    chk("rw_if_data", if_data, 32'd0);
    chk("rw_ls_rdata", ls_rdata, 32'd0);
    tick(); tick();
    chk("rw_nwrites", 32'(wa_q.size()), 32'd2);
    chk("rw_ram4001", 32'(ram[17'h04001]), 32'h22);
    chk("rw_ram4002", 32'(ram[17'h04002]), 32'h00);

    // Misaligned half load after reset
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h2001;
    tick();
    chk("hl_a_e0", mem_a, 32'h2001);
    tick();
    chk("hl_a_e1", mem_a, 32'h2002);
    tick();
    chk("hl_done_e2", 32'(ls_done), 32'd0);
    tick();
    chk("hl_done_e3", 32'(ls_done), 32'd1);
    chk("hl_rdata", ls_rdata, 32'h0000_BEEF);
    ls_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have no parameters; the IO region is fixed as addresses with addr[17:16]==2'b11.
REQ-002 clk_in  input  1  system clock; all state SHALL change on its rising edge only.
REQ-003 rst_in  input  1  reset, synchronous and active-high.
REQ-004 mem_din  input  8  byte read from RAM; valid one edge after its address was sampled by RAM.
REQ-005 mem_dout  output  8  byte to write.
REQ-006 mem_a  output  32  byte address to RAM/IO; RAM uses the low 17 bits.
REQ-007 mem_wr  output  1  1=write, 0=read.
REQ-008 io_buffer_full  input  1  IO output buffer full.
REQ-009 if_req  input  1  fetch request; held until if_done.
REQ-010 if_addr  input  32  fetch address, held with if_req.
REQ-011 if_done  output  1  one-cycle pulse; if_data valid while high.
REQ-012 if_data  output  32  fetched word, little-endian.
REQ-013 ls_req  input  1  load/store request; held until ls_done.
REQ-014 ls_wr  input  1  1=store, 0=load.
REQ-015 ls_size  input  2  0=byte, 1=half, 2=word, 3=treated as word.
REQ-016 ls_addr  input  32  byte address; misaligned allowed.
REQ-017 ls_wdata  input  32  store data; low N bytes used.
REQ-018 ls_done  output  1  one-cycle pulse; ls_rdata valid while high.
REQ-019 ls_rdata  output  32  load data, zero-extended.
REQ-020 clear  input  1  pipeline flush.

Function
REQ-021 States SHALL be IDLE, READ and WRITE; N = byte count (1/2/4; 4 for fetch).
REQ-022 IDLE SHALL accept a request at an edge where req is high, clear is low, and neither done is high.
REQ-023 If ls_req and if_req are both high at acceptance, ls SHALL win; fetch waits.
REQ-024 Acceptance SHALL latch address, size, direction, data and requester, reset byte counter k to 0, and enter READ or WRITE.
REQ-025 Byte k SHALL use address base+k, 32-bit wrap, little-endian (byte k = data[8k+7:8k]).
REQ-026 READ: acceptance edge = edge 0; mem_a=base+k, mem_wr=0 during cycle after edge k (k<N); byte k SHALL be captured from mem_din at edge k+2.
REQ-027 READ: at edge N+1 the last byte SHALL be captured, done of the owner set for exactly one cycle, state to IDLE; fetch latency 5 edges.
REQ-028 WRITE: mem_a=base+k, mem_dout=byte k, mem_wr=1 during cycle after edge k; at edge N, ls_done SHALL be set for one cycle and state to IDLE.
REQ-029 WRITE to IO address while io_buffer_full is high SHALL hold: mem_wr=0, k unchanged, until io_buffer_full is low; each stalled cycle adds one to latency.
REQ-030 In IDLE, mem_wr SHALL be 0 and mem_a/mem_dout SHALL hold their last values.
REQ-031 clear high at an edge in READ SHALL abort: state to IDLE, no done pulse, partial data discarded.
REQ-032 clear in WRITE SHALL be ignored; the store completes and ls_done pulses normally.
REQ-033 clear in IDLE SHALL block acceptance at that edge only.
REQ-034 mem_wr SHALL never be 1 outside WRITE, and no byte SHALL be written twice per request.
REQ-035 if_data/ls_rdata SHALL hold value after done until the next completion of the same port.

Reset
REQ-036 rst_in high at an edge SHALL force IDLE, k=0, mem_wr=0, mem_a=0, mem_dout=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0, in any state.
REQ-037 Reset mid-WRITE SHALL stop writing the next cycle; remaining bytes are not written; no done pulse.

Verification
REQ-038 RAM[0x1000..0x1003]=13 05 00 00, if_req at 0x1000 -> if_data=0x00000513, if_done high after edge 5, one cycle.
REQ-039 ls store size=1 data 0x0000BEEF at 0x2001 -> mem_wr pulses writing EF@0x2001, BE@0x2002, ls_done after edge 2, no other writes.
REQ-040 if_req and ls_req (load byte 0x80 @0x10) same edge -> ls_rdata=0x00000080 first; fetch accepted the edge after ls_done drops.
REQ-041 store byte 0x41 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr=0 for 3 cycles, then one write of 0x41, ls_done one cycle later.
REQ-042 clear at edge 2 of fetch -> no if_done, IDLE at edge 3; clear at edge 1 of word store -> all 4 bytes written, ls_done pulses.
REQ-043 rst_in at edge 2 of word store -> only bytes 0-1 written, all outputs zero, IDLE accepts next request.
